// File: rtl/uart_rx_to_axis_if.sv
// AXI-Stream link carrying received UART words with per-word status on tuser.
interface uart_rx_to_axis_if;
  logic [7:0] tdata;
  logic [1:0] tuser;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_to_axis.sv
// UART receiver: oversampling-free centre sampling of each bit, one-word AXI-Stream
// output with parity/framing status on tuser and an overrun pulse on backpressure.
module uart_rx_to_axis #(
  parameter int CLK_FREQ      = 100,
  parameter int BIT_RATE      = 115200,
  parameter int BIT_PER_WORD  = 8,
  parameter int PARITY_BIT    = 0,
  parameter int STOP_BITS_NUM = 1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               RX,
  uart_rx_to_axis_if.master  axis,
  output logic               overrun
);

  localparam int unsigned P = (CLK_FREQ * 1000000) / BIT_RATE;
  localparam int unsigned H = P / 2;
  localparam logic [17:0] C_P_LAST   = 18'(P - 1);
  localparam logic [17:0] C_H_LAST   = 18'(H - 1);
  localparam logic [3:0]  C_LAST_BIT = 4'(BIT_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [17:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_perr, w_perr_nxt;
  logic        r_ferr, w_ferr_nxt;
  logic        w_done;
  logic        w_tick;
  logic        w_par_exp;

  logic        r_sync1, r_rx_s, r_rx_d;
  logic [1:0]  r_fill;
  logic        r_line_ok;

  logic [7:0]  r_tdata;
  logic [1:0]  r_tuser;
  logic        r_tvalid;
  logic        r_overrun;

  // r_line_ok blocks edge detection until a genuine high has passed through the
  // synchronizer, so a line held low across reset release cannot fake a start bit.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
      r_fill    <= '0;
      r_line_ok <= 1'b0;
    end else begin
      r_sync1 <= RX;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
      r_fill  <= {r_fill[0], 1'b1};
      if (r_fill[1] && r_rx_s)
        r_line_ok <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_perr  <= w_perr_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_ferr_nxt  = r_ferr;
    w_done      = 1'b0;
    w_tick      = (r_cnt == C_P_LAST);
    w_par_exp   = (PARITY_BIT == 1) ? ~^r_shift : ^r_shift;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (r_line_ok && r_rx_d && !r_rx_s)
          w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == C_H_LAST) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_shift_nxt = '0;
            w_bit_nxt   = '0;
            w_perr_nxt  = 1'b0;
            w_ferr_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 18'd1;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt                = '0;
          w_shift_nxt[r_bit[2:0]]  = r_rx_s;
          w_bit_nxt                = r_bit + 4'd1;
          if (r_bit == C_LAST_BIT)
            w_state_nxt = (PARITY_BIT != 0) ? S_PARITY : S_STOP1;
        end else begin
          w_cnt_nxt = r_cnt + 18'd1;
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (r_rx_s != w_par_exp)
            w_perr_nxt = 1'b1;
          w_state_nxt = S_STOP1;
        end else begin
          w_cnt_nxt = r_cnt + 18'd1;
        end
      end
      S_STOP1: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (!r_rx_s)
            w_ferr_nxt = 1'b1;
          if (STOP_BITS_NUM == 2) begin
            w_state_nxt = S_STOP2;
          end else begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 18'd1;
        end
      end
      S_STOP2: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (!r_rx_s)
            w_ferr_nxt = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 18'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A completed word is accepted only if the holding register frees this cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_tdata   <= '0;
      r_tuser   <= '0;
      r_tvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        if (!r_tvalid || axis.tready) begin
          r_tdata  <= w_shift_nxt;
          r_tuser  <= {w_ferr_nxt, w_perr_nxt};
          r_tvalid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_tvalid && axis.tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign axis.tdata  = r_tdata;
  assign axis.tuser  = r_tuser;
  assign axis.tvalid = r_tvalid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_to_axis.sv
// Directed bench for uart_rx_to_axis: four instances covering 8N1 at the default
// rate, 8N1 fast, 8E1 fast and 7N2 fast.
module tb_uart_rx_to_axis;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic rx_line [4];
  logic ovr [4];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int          n_xfer [4];
  int          n_vcyc [4];
  int          n_ovr  [4];
  logic [7:0]  last_data [4];
  logic [1:0]  last_user [4];
  logic        tv [4];
  logic        tr [4];
  logic [7:0]  td [4];
  logic [1:0]  tu [4];

  uart_rx_to_axis_if ax0 ();
  uart_rx_to_axis_if ax1 ();
  uart_rx_to_axis_if ax2 ();
  uart_rx_to_axis_if ax3 ();

  always #5 aclk = ~aclk;

  uart_rx_to_axis u0 (
    .aclk(aclk), .aresetn(aresetn), .RX(rx_line[0]), .axis(ax0), .overrun(ovr[0])
  );

  uart_rx_to_axis #(
    .CLK_FREQ(2), .BIT_RATE(62500), .BIT_PER_WORD(8), .PARITY_BIT(0), .STOP_BITS_NUM(1)
  ) u1 (
    .aclk(aclk), .aresetn(aresetn), .RX(rx_line[1]), .axis(ax1), .overrun(ovr[1])
  );

  uart_rx_to_axis #(
    .CLK_FREQ(2), .BIT_RATE(62500), .BIT_PER_WORD(8), .PARITY_BIT(2), .STOP_BITS_NUM(1)
  ) u2 (
    .aclk(aclk), .aresetn(aresetn), .RX(rx_line[2]), .axis(ax2), .overrun(ovr[2])
  );

  uart_rx_to_axis #(
    .CLK_FREQ(2), .BIT_RATE(62500), .BIT_PER_WORD(7), .PARITY_BIT(0), .STOP_BITS_NUM(2)
  ) u3 (
    .aclk(aclk), .aresetn(aresetn), .RX(rx_line[3]), .axis(ax3), .overrun(ovr[3])
  );

  assign tv[0] = ax0.tvalid; assign tr[0] = ax0.tready; assign td[0] = ax0.tdata; assign tu[0] = ax0.tuser;
  assign tv[1] = ax1.tvalid; assign tr[1] = ax1.tready; assign td[1] = ax1.tdata; assign tu[1] = ax1.tuser;
  assign tv[2] = ax2.tvalid; assign tr[2] = ax2.tready; assign td[2] = ax2.tdata; assign tu[2] = ax2.tuser;
  assign tv[3] = ax3.tvalid; assign tr[3] = ax3.tready; assign td[3] = ax3.tdata; assign tu[3] = ax3.tuser;

  initial begin
    for (int i = 0; i < 4; i++) begin
      n_xfer[i] = 0; n_vcyc[i] = 0; n_ovr[i] = 0;
      last_data[i] = '0; last_user[i] = '0;
    end
  end

  always @(negedge aclk) begin
    for (int i = 0; i < 4; i++) begin
      if (tv[i] === 1'b1) n_vcyc[i]++;
      if (tv[i] === 1'b1 && tr[i] === 1'b1) begin
        n_xfer[i]++;
        last_data[i] = td[i];
        last_user[i] = tu[i];
      end
      if (ovr[i] === 1'b1) n_ovr[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic bit_out(input int unsigned inst, input logic b, input int unsigned p);
    rx_line[inst] = b;
    wait_clk(p);
  endtask

  task automatic send(input int unsigned inst, input int unsigned p, input int unsigned nbits,
                      input logic [7:0] data, input int unsigned pmode, input logic pflip,
                      input int unsigned nstop, input logic s1, input logic s2);
    logic par;
    par = 1'b0;
    bit_out(inst, 1'b0, p);
    for (int unsigned i = 0; i < nbits; i++) begin
      bit_out(inst, data[i], p);
      par = par ^ data[i];
    end
    if (pmode != 0) bit_out(inst, ((pmode == 1) ? ~par : par) ^ pflip, p);
    bit_out(inst, s1, p);
    if (nstop == 2) bit_out(inst, s2, p);
    rx_line[inst] = 1'b1;
  endtask

  int bx, bo;

  initial begin
    for (int i = 0; i < 4; i++) rx_line[i] = 1'b1;
    ax0.tready = 1'b1; ax1.tready = 1'b1; ax2.tready = 1'b1; ax3.tready = 1'b1;
    aresetn = 1'b0;
    wait_clk(5);
    check("rst_tvalid",  32'(ax0.tvalid), 32'd0);
    check("rst_tdata",   32'(ax0.tdata),  32'd0);
    check("rst_tuser",   32'(ax0.tuser),  32'd0);
    check("rst_overrun", 32'(ovr[0]),     32'd0);
    aresetn = 1'b1;
    wait_clk(10);

    // 8N1 defaults, 0xA5
    send(0, 868, 8, 8'hA5, 0, 1'b0, 1, 1'b1, 1'b1);
    wait_clk(100);
    check("a5_xfers", 32'(n_xfer[0]), 32'd1);
    check("a5_data",  32'(last_data[0]), 32'hA5);
    check("a5_user",  32'(last_user[0]), 32'd0);
    check("a5_vcyc",  32'(n_vcyc[0]), 32'd1);

    // 300-clock glitch shorter than the half period
    rx_line[0] = 1'b0;
    wait_clk(300);
    rx_line[0] = 1'b1;
    wait_clk(1000);
    check("glitch_xfers", 32'(n_xfer[0]), 32'd1);
    check("glitch_vcyc",  32'(n_vcyc[0]), 32'd1);
    send(0, 868, 8, 8'h81, 0, 1'b0, 1, 1'b1, 1'b1);
    wait_clk(100);
    check("x81_xfers", 32'(n_xfer[0]), 32'd2);
    check("x81_data",  32'(last_data[0]), 32'h81);
    check("x81_user",  32'(last_user[0]), 32'd0);
    check("u0_ovr",    32'(n_ovr[0]), 32'd0);

    // 8E1: 0x3C with parity forced wrong, then 0x07 with parity correct
    send(2, 32, 8, 8'h3C, 2, 1'b1, 1, 1'b1, 1'b1);
    wait_clk(40);
    check("par_bad_data", 32'(last_data[2]), 32'h3C);
    check("par_bad_user", 32'(last_user[2]), 32'd1);
    send(2, 32, 8, 8'h07, 2, 1'b0, 1, 1'b1, 1'b1);
    wait_clk(40);
    check("par_ok_data",  32'(last_data[2]), 32'h07);
    check("par_ok_user",  32'(last_user[2]), 32'd0);
    check("par_xfers",    32'(n_xfer[2]), 32'd2);

    // 8N1 fast: framing error, then clean frame clears status
    send(1, 32, 8, 8'h55, 0, 1'b0, 1, 1'b0, 1'b1);
    wait_clk(64);
    check("ferr_data", 32'(last_data[1]), 32'h55);
    check("ferr_user", 32'(last_user[1]), 32'd2);
    send(1, 32, 8, 8'h0F, 0, 1'b0, 1, 1'b1, 1'b1);
    wait_clk(40);
    check("clean_data", 32'(last_data[1]), 32'h0F);
    check("clean_user", 32'(last_user[1]), 32'd0);

    // Backpressure: 0x11 held, 0x22 dropped with one overrun pulse
    bx = n_xfer[1];
    bo = n_ovr[1];
    ax1.tready = 1'b0;
    send(1, 32, 8, 8'h11, 0, 1'b0, 1, 1'b1, 1'b1);
    send(1, 32, 8, 8'h22, 0, 1'b0, 1, 1'b1, 1'b1);
    wait_clk(40);
    check("ovr_tvalid", 32'(ax1.tvalid), 32'd1);
    check("ovr_tdata",  32'(ax1.tdata),  32'h11);
    check("ovr_pulses", 32'(n_ovr[1] - bo), 32'd1);
    check("ovr_noxfer", 32'(n_xfer[1] - bx), 32'd0);
    ax1.tready = 1'b1;
    wait_clk(5);
    check("ovr_drain_xfers", 32'(n_xfer[1] - bx), 32'd1);
    check("ovr_drain_data",  32'(last_data[1]), 32'h11);
    check("ovr_drain_valid", 32'(ax1.tvalid), 32'd0);

    // Reset during the data bits of 0xFF, then 0x42
    bx = n_xfer[1];
    bit_out(1, 1'b0, 32);
    bit_out(1, 1'b1, 64);
    aresetn = 1'b0;
    wait_clk(3);
    check("mid_rst_tdata", 32'(ax1.tdata), 32'd0);
    check("mid_rst_valid", 32'(ax1.tvalid), 32'd0);
    aresetn = 1'b1;
    wait_clk(256);
    check("mid_rst_noxfer", 32'(n_xfer[1] - bx), 32'd0);
    send(1, 32, 8, 8'h42, 0, 1'b0, 1, 1'b1, 1'b1);
    wait_clk(40);
    check("x42_xfers", 32'(n_xfer[1] - bx), 32'd1);
    check("x42_data",  32'(last_data[1]), 32'h42);

    // 7N2: good frame, then second stop bit low
    send(3, 32, 7, 8'h7E, 0, 1'b0, 2, 1'b1, 1'b1);
    wait_clk(40);
    check("7n2_data",  32'(last_data[3]), 32'h7E);
    check("7n2_user",  32'(last_user[3]), 32'd0);
    send(3, 32, 7, 8'h7E, 0, 1'b0, 2, 1'b1, 1'b0);
    wait_clk(40);
    check("7n2_stop2_data", 32'(last_data[3]), 32'h7E);
    check("7n2_stop2_user", 32'(last_user[3]), 32'd2);
    check("7n2_xfers",      32'(n_xfer[3]), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_to_axis.md
# uart_rx_to_axis

Receives asynchronous UART frames on a single serial line and presents each received data word as a one-word AXI-Stream master transfer. It is the receive-side counterpart of the UART transmit path and uses the same parameter set, so one parameter set configures both ends of a link. Per-word parity and framing status travel on `tuser`. An overrun pulse flags words lost to downstream backpressure.

## Interface
- `CLK_FREQ`, 100: clock frequency in MHz.
- `BIT_RATE`, 115200: line rate in bit/s.
- `BIT_PER_WORD`, 8: data bits per frame, legal range 5..8.
- `PARITY_BIT`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS_NUM`, 1: stop bits per frame, 1 or 2.
- `aclk`  in  1  clock; all logic on the rising edge.
- `aresetn`  in  1  reset, synchronous, active-low.
- `RX`  in  1  asynchronous UART line; idles high.
- `tdata`  out  8  received word, LSB = first data bit; bits above `BIT_PER_WORD-1` are 0.
- `tuser`  out  2  status of the word on `tdata`; bit0 = parity error, bit1 = framing error.
- `tvalid`  out  1  a word is held.
- `tready`  in  1  downstream accept.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.

## Operation
- Bit period: `P = CLK_FREQ*10**6/BIT_RATE` clocks, integer division; 868 at the defaults. Half period: `H = P/2` (434).
- Clock counter: 18 bits.
- Data bit counter: 4 bits.
- Input synchronizer: two flops, both reset to 1. All decisions use the second flop (`rx_s`). A third flop (`rx_d`) holds the previous `rx_s` for edge detection.
- State machine: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: clock counter held at 0. Leave on a falling edge (`rx_d`=1, `rx_s`=0) → START. A line that is low at reset release does not start a frame until it has gone high.
  - START: count to `H-1`, then sample `rx_s`.
    - Sample 0: → DATA, clock counter cleared.
    - Sample 1: glitch, → IDLE with nothing emitted.
  - DATA: count to `P-1`, sample `rx_s` into the shift register LSB-first, increment the bit counter.
    - After bit `BIT_PER_WORD-1`: → PARITY if `PARITY_BIT`≠0, else → STOP1.
  - PARITY: sample once at `P-1`. Expected value:
    - odd mode: `~^data`
    - even mode: `^data`
    - A mismatch sets the pending parity error. Then → STOP1.
  - STOP1: sample at `P-1`; a 0 sets the pending framing error.
    - `STOP_BITS_NUM`=2: → STOP2.
    - Otherwise: the word completes, → IDLE.
  - STOP2: sample at `P-1`; a 0 also sets the framing error. The word completes, → IDLE.
- Returning to IDLE at the centre of the final stop bit allows a start bit immediately after it to be detected.
- Word completion:
  - If `tvalid`=0, or `tvalid`=1 and `tready`=1 in the same cycle: load `tdata`/`tuser` from the new word and set `tvalid`=1.
  - If `tvalid`=1 and `tready`=0: drop the new word, leave the held `tdata`/`tuser`/`tvalid` untouched, and pulse `overrun` for one cycle.
- Words with errors are still delivered; error bits are not sticky across words.
- AXI-Stream rules:
  - `tvalid` does not depend on `tready`.
  - Once `tvalid` is high, `tdata`/`tuser` stay stable until a cycle with `tvalid`=`tready`=1.
  - After that handshake `tvalid` drops the next cycle unless a new word completes in the same cycle.
  - Reception never stalls; backpressure only causes overrun.

## Timing
- Reset values:
  - `tvalid`=0, `tdata`=0, `tuser`=0, `overrun`=0.
  - State = IDLE, both counters 0, synchronizer = 1.
- Reset mid-frame: the partial frame is discarded, no output is produced, and the block returns to IDLE on the next edge.
- Input latency: 2 clocks from `RX` to `rx_s`.
- Start sample: `H` clocks after the falling edge is seen on `rx_s`. Bit n sample: `H + (n+1)*P` clocks after that edge.
- Output latency: `tvalid` and the new `tdata`/`tuser` are visible the clock after the final stop-bit sample.
- `overrun` is registered and asserts the same clock that a loaded word would have appeared.
- Throughput: back-to-back frames at the full line rate are supported; sustained operation without overrun requires `tready` high at least once per frame.

## Test plan
- 8N1 at the defaults, send 0xA5 with `tready`=1 → one transfer, `tdata`=0xA5, `tuser`=0, `tvalid` high for exactly 1 cycle.
- `PARITY_BIT`=2, send 0x3C with parity bit 1 (correct value 0) → `tdata`=0x3C, `tuser`=2'b01.
- Send 0x55 with the stop bit driven 0 → `tdata`=0x55, `tuser`=2'b10. Next frame 0x0F with a good stop bit → `tuser`=2'b00.
- Low pulse of 300 clocks on an idle line → no `tvalid`. A following valid 0x81 frame is received correctly.
- `tready`=0, send 0x11 then 0x22 back-to-back → `tdata`=0x11 held, one `overrun` pulse at the end of 0x22. Then raise `tready` → single transfer of 0x11.
- Assert `aresetn`=0 during the DATA bits of 0xFF, release, then send 0x42 → only 0x42 is delivered.
- `STOP_BITS_NUM`=2, `BIT_PER_WORD`=7, send 0x7E → `tdata`=0x7E. With the second stop bit driven 0 → `tuser`=2'b10.
